wb_regfile: RTL and testbench

- Register-file write stage directly downstream of the writeback stage.
- Consumes wb_rd, wb_mask and wb_mre, and commits byte-masked writes into a 16 x 32-bit register file.
  - ALU results are written on the next clock edge.
  - Loads stall the pipeline until memory read data returns.
- Provides two combinational read ports to decode, a pending-load tag for hazard logic, and a stall-cycle counter.

---
 rtl/wb_regfile.sv | 181 ++++++++++++++++++
 tb/tb_wb_regfile.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Register-file write stage: byte-masked writes into 16 x 32-bit registers, load-stall FSM, stall counter.
// Optional macro WB_REGFILE_BYPASS_EN forwards the merged post-write value to the read ports.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREG  = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       wb_rd,
  input  logic [3:0]       wb_mask,
  input  logic             wb_mre,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_rvalid,
  input  logic [3:0]       rs1_addr,
  input  logic [3:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             n_stall,
  output logic             pend_valid,
  output logic [3:0]       pend_rd,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [3:0]        pend_rd_q, pend_rd_d;
  logic [3:0]        pend_mask_q, pend_mask_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0]   regs_q [NREG];

  logic              wr_en_s;
  logic [3:0]        wr_rd_s;
  logic [3:0]        wr_mask_s;
  logic [XLEN-1:0]   wr_data_s;

  function automatic logic [XLEN-1:0] lane_merge(input logic [XLEN-1:0] old_v,
                                                 input logic [XLEN-1:0] new_v,
                                                 input logic [3:0]      mask);
    logic [XLEN-1:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_rd_q   <= 4'd0;
      pend_mask_q <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_rd_q   <= pend_rd_d;
      pend_mask_q <= pend_mask_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_rd_d   = pend_rd_q;
    pend_mask_d = pend_mask_q;
    case (state_q)
      IDLE: begin
        if (wb_mre && !mem_rvalid && (wb_rd != 4'd0)) begin
          state_d     = WAIT;
          pend_rd_d   = wb_rd;
          pend_mask_d = wb_mask;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d     = IDLE;
          pend_rd_d   = 4'd0;
          pend_mask_d = 4'd0;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d     = IDLE;
        pend_rd_d   = 4'd0;
        pend_mask_d = 4'd0;
      end
    endcase
  end

  // Outputs and the single write port; zero-mask or r0 writes are suppressed here.
  always_comb begin
    n_stall    = 1'b1;
    pend_valid = 1'b0;
    wr_en_s    = 1'b0;
    wr_rd_s    = 4'd0;
    wr_mask_s  = 4'd0;
    wr_data_s  = '0;
    case (state_q)
      IDLE: begin
        wr_rd_s   = wb_rd;
        wr_mask_s = wb_mask;
        if (!wb_mre) begin
          wr_data_s = alu_result;
          wr_en_s   = (wb_rd != 4'd0) && (wb_mask != 4'd0);
        end else if (mem_rvalid) begin
          wr_data_s = mem_rdata;
          wr_en_s   = (wb_rd != 4'd0) && (wb_mask != 4'd0);
        end else begin
          n_stall = (wb_rd == 4'd0);
        end
      end
      WAIT: begin
        pend_valid = 1'b1;
        n_stall    = mem_rvalid;
        wr_rd_s    = pend_rd_q;
        wr_mask_s  = pend_mask_q;
        wr_data_s  = mem_rdata;
        wr_en_s    = mem_rvalid && (pend_rd_q != 4'd0) && (pend_mask_q != 4'd0);
      end
      default: begin
        n_stall = 1'b1;
      end
    endcase
  end

  always_comb begin
    if (!n_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (wr_en_s && (wr_rd_s == 4'(i))) begin
          regs_q[i] <= lane_merge(regs_q[i], wr_data_s, wr_mask_s);
        end else begin
          regs_q[i] <= regs_q[i];
        end
      end
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [3:0] addr);
    logic [XLEN-1:0] res;
    if (addr == 4'd0) begin
      res = '0;
`ifdef WB_REGFILE_BYPASS_EN
    end else if (wr_en_s && (addr == wr_rd_s)) begin
      res = lane_merge(regs_q[addr], wr_data_s, wr_mask_s);
`endif
    end else begin
      res = regs_q[addr];
    end
    return res;
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_addr);
    rs2_data = read_port(rs2_addr);
  end

  assign pend_rd   = pend_rd_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized and directed self-checking bench for wb_regfile against a behavioural register-file model.
module tb_wb_regfile;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    wb_rd, wb_mask, rs1_addr, rs2_addr;
  logic          wb_mre, mem_rvalid;
  logic [31:0]   alu_result, mem_rdata;
  logic [31:0]   rs1_data, rs2_data;
  logic          n_stall, pend_valid;
  logic [3:0]    pend_rd;
  logic [CW-1:0] stall_cnt;

  wb_regfile #(.XLEN(32), .NREG(16), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .wb_rd(wb_rd), .wb_mask(wb_mask), .wb_mre(wb_mre),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .n_stall(n_stall), .pend_valid(pend_valid), .pend_rd(pend_rd), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mdl [16];
  bit          m_wait;
  logic [3:0]  m_prd, m_pmask;
  int          m_cnt;
  bit          w_en;
  logic [3:0]  w_rd, w_mask;
  logic [31:0] w_data;
  bit          e_nstall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_read(input logic [3:0] a);
    if (a == 4'd0) return 32'h0;
`ifdef WB_REGFILE_BYPASS_EN
    if (w_en && a == w_rd) return merge(mdl[a], w_data, w_mask);
`endif
    return mdl[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    m_wait = 1'b0; m_prd = 4'd0; m_pmask = 4'd0; m_cnt = 0;
  endtask

  // Work out what this cycle should do, then compare every observable output.
  task automatic eval_and_check();
    w_en = 1'b0; w_rd = 4'd0; w_mask = 4'd0; w_data = 32'h0;
    if (m_wait) begin
      e_nstall = mem_rvalid;
      if (mem_rvalid && m_pmask != 4'd0) begin
        w_en = 1'b1; w_rd = m_prd; w_mask = m_pmask; w_data = mem_rdata;
      end
    end else begin
      e_nstall = !(wb_mre && !mem_rvalid && wb_rd != 4'd0);
      if (wb_rd != 4'd0 && wb_mask != 4'd0 && (!wb_mre || mem_rvalid)) begin
        w_en = 1'b1; w_rd = wb_rd; w_mask = wb_mask;
        w_data = wb_mre ? mem_rdata : alu_result;
      end
    end
    check("n_stall", 32'(n_stall), 32'(e_nstall));
    check("pend_valid", 32'(pend_valid), 32'(m_wait));
    check("pend_rd", 32'(pend_rd), m_wait ? 32'(m_prd) : 32'h0);
    check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    check("rs1_data", rs1_data, exp_read(rs1_addr));
    check("rs2_data", rs2_data, exp_read(rs2_addr));
  endtask

  task automatic model_commit();
    if (w_en) mdl[w_rd] = merge(mdl[w_rd], w_data, w_mask);
    if (!e_nstall && m_cnt < (1 << CW) - 1) m_cnt++;
    if (m_wait) begin
      if (mem_rvalid) begin m_wait = 1'b0; m_prd = 4'd0; m_pmask = 4'd0; end
    end else if (wb_mre && !mem_rvalid && wb_rd != 4'd0) begin
      m_wait = 1'b1; m_prd = wb_rd; m_pmask = wb_mask;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    eval_and_check();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic drive(input logic [3:0] rd, input logic [3:0] mask, input logic mre,
                       input logic [31:0] alu, input logic [31:0] mdat, input logic rv,
                       input logic [3:0] a1, input logic [3:0] a2);
    wb_rd = rd; wb_mask = mask; wb_mre = mre; alu_result = alu;
    mem_rdata = mdat; mem_rvalid = rv; rs1_addr = a1; rs2_addr = a2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(4'd0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_pend_valid", 32'(pend_valid), 32'h0);
    check("rst_async_n_stall", 32'(n_stall), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    drive(4'd0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0);
    model_reset();
    #1 rst = 1'b1;
    #12 rst = 1'b0;
    @(posedge clk); #1;

    // reset contents
    for (int i = 1; i < 16; i++) begin
      drive(4'd0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 4'(i), 4'(16 - i));
      #1 check("reset_reg", rs1_data, 32'h0);
      cycle();
    end
    check("reset_stall_cnt", 32'(stall_cnt), 32'h0);

    // ALU full write then byte-lane write to r3
    drive(4'd3, 4'b1111, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 4'd3, 4'd0);
    cycle();
    drive(4'd3, 4'b0010, 1'b0, 32'h0000AA00, 32'h0, 1'b0, 4'd3, 4'd3);
    #1 check("alu_r3_full", rs2_data, 32'hDEADBEEF);
    cycle();
    drive(4'd0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd3, 4'd0);
    #1 check("alu_r3_lane", rs1_data, 32'hDEADAAEF);
    cycle();

    // load to r5 with three stall cycles
    drive(4'd5, 4'b1111, 1'b1, 32'h0, 32'h0, 1'b0, 4'd5, 4'd0);
    cycle();
    drive(4'd9, 4'b1111, 1'b0, 32'h11111111, 32'h0, 1'b0, 4'd5, 4'd9);
    #1 check("load_pend_rd", 32'(pend_rd), 32'h5);
    cycle();
    cycle();
    drive(4'd9, 4'b1111, 1'b0, 32'h11111111, 32'h12345678, 1'b1, 4'd5, 4'd9);
    cycle();
    drive(4'd0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd5, 4'd9);
    #1 check("load_r5", rs1_data, 32'h12345678);
    check("load_r9_ignored", rs2_data, 32'h0);
    check("load_stall_cnt", 32'(stall_cnt), 32'h3);
    check("load_done_pend", 32'(pend_valid), 32'h0);
    cycle();

    // bubble, r0 write, stray rvalid
    drive(4'd0, 4'b1111, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, 4'd0, 4'd3);
    cycle();
    drive(4'd0, 4'b1111, 1'b1, 32'h0, 32'hFFFFFFFF, 1'b1, 4'd0, 4'd5);
    cycle();
    drive(4'd0, 4'b1111, 1'b1, 32'h0, 32'h0, 1'b0, 4'd0, 4'd5);
    cycle();
    drive(4'd0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 4'd3);
    #1 check("r0_reads_zero", rs1_data, 32'h0);
    check("bubble_r3_kept", rs2_data, 32'hDEADAAEF);
    cycle();

    // reset while waiting on a load to r7
    drive(4'd7, 4'b1111, 1'b1, 32'h0, 32'h0, 1'b0, 4'd7, 4'd0);
    cycle();
    cycle();
    check("wait_pend_rd7", 32'(pend_rd), 32'h7);
    do_reset();
    drive(4'd0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd7, 4'd3);
    #1 check("rst_wait_r7", rs1_data, 32'h0);
    check("rst_wait_idle", 32'(pend_valid), 32'h0);
    check("rst_wait_r3", rs2_data, 32'h0);
    cycle();

    // same-cycle write and read of r4
    drive(4'd4, 4'b1111, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0, 4'd0, 4'd4);
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    check("bypass_r4", rs2_data, 32'hCAFEF00D);
`else
    check("bypass_r4", rs2_data, 32'h0);
`endif
    cycle();

    // randomized traffic; counter width small enough to saturate
    for (int n = 0; n < 800; n++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 4),
            $urandom, $urandom, ($urandom_range(0, 9) < 3),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      cycle();
    end
    check("stall_cnt_saturated", 32'(stall_cnt), 32'((1 << CW) - 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
